// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge filter over a raster pixel stream.
// Two line buffers feed a 3x3 window, followed by gradient, magnitude and output stages.
module sobel_stream #(
    parameter int DW    = 8,
    parameter int IMG_W = 857,
    parameter int IMG_H = 480
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic          in_sof,
    input  logic [DW-1:0] in_pixel,
    input  logic [1:0]    mode,
    input  logic [DW+3:0] thresh,
    output logic          out_valid,
    output logic [DW-1:0] out_pixel,
    output logic          out_sof,
    output logic          out_eol,
    output logic          frame_done
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int GW = DW + 3;
    localparam int MW = DW + 4;
    localparam logic [DW-1:0] PMAX = '1;

    // Input side: position tracking and per-frame mode/threshold
    logic          synced_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic [1:0]    mode_q;
    logic [MW-1:0] thresh_q;

    logic          beat;
    logic [CW-1:0] pos_col;
    logic [RW-1:0] pos_row;
    logic [1:0]    beat_mode;
    logic [MW-1:0] beat_thresh;
    logic          pos_eol;

    // Until an in_sof beat is seen after reset, the stream position is unknown
    assign beat        = in_valid && (in_sof || synced_q);
    assign pos_col     = in_sof ? '0 : col_q;
    assign pos_row     = in_sof ? '0 : row_q;
    assign beat_mode   = in_sof ? mode : mode_q;
    assign beat_thresh = in_sof ? thresh : thresh_q;
    assign pos_eol     = (pos_col == CW'(IMG_W - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            synced_q <= 1'b0;
            col_q    <= '0;
            row_q    <= '0;
            mode_q   <= '0;
            thresh_q <= '0;
        end else if (beat) begin
            synced_q <= 1'b1;
            mode_q   <= beat_mode;
            thresh_q <= beat_thresh;
            if (pos_eol) begin
                col_q <= '0;
                row_q <= (pos_row == RW'(IMG_H - 1)) ? '0 : pos_row + 1'b1;
            end else begin
                col_q <= pos_col + 1'b1;
                row_q <= pos_row;
            end
        end
    end

    // Stage 1: beat capture and line buffer reads
    logic          s1_beat_q, s1_ok_q, s1_sof_q, s1_eol_q, s1_last_q;
    logic [CW-1:0] s1_col_q;
    logic [DW-1:0] s1_pix_q;
    logic [1:0]    s1_mode_q;
    logic [MW-1:0] s1_thr_q;
    logic [DW-1:0] lb0_rd_q, lb1_rd_q;
    logic [DW-1:0] lb0_mem [IMG_W];
    logic [DW-1:0] lb1_mem [IMG_W];

    always_ff @(posedge clk) begin
        if (!reset) s1_beat_q <= 1'b0;
        else        s1_beat_q <= beat;
    end

    always_ff @(posedge clk) begin
        if (beat) begin
            s1_col_q  <= pos_col;
            s1_pix_q  <= in_pixel;
            s1_ok_q   <= (pos_row >= RW'(2)) && (pos_col >= CW'(2));
            s1_sof_q  <= (pos_row == RW'(2)) && (pos_col == CW'(2));
            s1_eol_q  <= pos_eol;
            s1_last_q <= pos_eol && (pos_row == RW'(IMG_H - 1));
            s1_mode_q <= beat_mode;
            s1_thr_q  <= beat_thresh;
        end
    end

    // lb0 holds the previous line; lb1 receives lb0's old value one cycle later
    always_ff @(posedge clk) begin
        if (beat) begin
            lb0_mem[pos_col] <= in_pixel;
            lb0_rd_q         <= lb0_mem[pos_col];
            lb1_rd_q         <= lb1_mem[pos_col];
        end
        if (s1_beat_q) lb1_mem[s1_col_q] <= lb0_rd_q;
    end

    // Stage 2: 3x3 window, win_q[row][col], row 0 oldest line, col 2 newest
    logic [DW-1:0] win_q [3][3];
    logic          s2_valid_q, s2_sof_q, s2_eol_q, s2_last_q;
    logic [1:0]    s2_mode_q;
    logic [MW-1:0] s2_thr_q;

    always_ff @(posedge clk) begin
        if (s1_beat_q) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= lb1_rd_q;
            win_q[1][2] <= lb0_rd_q;
            win_q[2][2] <= s1_pix_q;
        end
        s2_sof_q  <= s1_sof_q;
        s2_eol_q  <= s1_eol_q;
        s2_last_q <= s1_last_q;
        s2_mode_q <= s1_mode_q;
        s2_thr_q  <= s1_thr_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) s2_valid_q <= 1'b0;
        else        s2_valid_q <= s1_beat_q && s1_ok_q;
    end

    // Stage 3: gradients and absolute values
    logic [GW-1:0] gx_d, gy_d;
    logic [MW-1:0] ax_d, ay_d;
    logic          s3_valid_q, s3_sof_q, s3_eol_q, s3_last_q;
    logic [1:0]    s3_mode_q;
    logic [MW-1:0] s3_thr_q, s3_ax_q, s3_ay_q;

    always_comb begin
        gx_d = (GW'(win_q[0][2]) + (GW'(win_q[1][2]) << 1) + GW'(win_q[2][2]))
             - (GW'(win_q[0][0]) + (GW'(win_q[1][0]) << 1) + GW'(win_q[2][0]));
        gy_d = (GW'(win_q[2][0]) + (GW'(win_q[2][1]) << 1) + GW'(win_q[2][2]))
             - (GW'(win_q[0][0]) + (GW'(win_q[0][1]) << 1) + GW'(win_q[0][2]));
        ax_d = MW'(gx_d[GW-1] ? (~gx_d + 1'b1) : gx_d);
        ay_d = MW'(gy_d[GW-1] ? (~gy_d + 1'b1) : gy_d);
    end

    always_ff @(posedge clk) begin
        s3_ax_q   <= ax_d;
        s3_ay_q   <= ay_d;
        s3_sof_q  <= s2_sof_q;
        s3_eol_q  <= s2_eol_q;
        s3_last_q <= s2_last_q;
        s3_mode_q <= s2_mode_q;
        s3_thr_q  <= s2_thr_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) s3_valid_q <= 1'b0;
        else        s3_valid_q <= s2_valid_q;
    end

    // Output stage: mode select and saturation
    logic [MW-1:0] sum_d;
    logic [DW-1:0] res_d;
    logic          out_valid_q, out_sof_q, out_eol_q, out_last_q, frame_done_q;
    logic [DW-1:0] out_pixel_q;

    function automatic logic [DW-1:0] sat(input logic [MW-1:0] v);
        return (v > MW'(PMAX)) ? PMAX : v[DW-1:0];
    endfunction

    always_comb begin
        sum_d = s3_ax_q + s3_ay_q;
        res_d = '0;
        case (s3_mode_q)
            2'b00:   res_d = sat(s3_ax_q);
            2'b01:   res_d = sat(s3_ay_q);
            2'b10:   res_d = sat(sum_d);
            default: res_d = (sum_d >= s3_thr_q) ? PMAX : '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_q  <= 1'b0;
            out_pixel_q  <= '0;
            out_sof_q    <= 1'b0;
            out_eol_q    <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            out_valid_q  <= s3_valid_q;
            out_pixel_q  <= s3_valid_q ? res_d : '0;
            out_sof_q    <= s3_valid_q && s3_sof_q;
            out_eol_q    <= s3_valid_q && s3_eol_q;
            out_last_q   <= s3_valid_q && s3_last_q;
            frame_done_q <= out_valid_q && out_last_q;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_pixel  = out_pixel_q;
    assign out_sof    = out_sof_q;
    assign out_eol    = out_eol_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_sobel_stream.sv
// Directed bench for sobel_stream on an 8x6 frame: constant, step and ramp images,
// input gaps, mid-frame reset and mid-frame resync.
module tb_sobel_stream;
    localparam int DW = 8;
    localparam int W  = 8;
    localparam int H  = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic [DW-1:0] in_pixel = '0;
    logic [1:0]    mode = '0;
    logic [DW+3:0] thresh = '0;
    logic          out_valid, out_sof, out_eol, frame_done;
    logic [DW-1:0] out_pixel;

    sobel_stream #(.DW(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof),
        .in_pixel(in_pixel), .mode(mode), .thresh(thresh),
        .out_valid(out_valid), .out_pixel(out_pixel), .out_sof(out_sof),
        .out_eol(out_eol), .frame_done(frame_done)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int pix;
        int sof;
        int eol;
        int last;
        int t;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_out = 0;
    int   n_done = 0;
    int   idle_bad = 0;
    int   done_pend = 0;

    task automatic check(input string tag, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp_v);
        end
    endtask

    // kind 0: constant 100, kind 1: vertical step at col 4, kind 2: ramp 10*col
    function automatic int pix_of(input int kind, input int c);
        if (kind == 0) return 100;
        if (kind == 1) return (c < 4) ? 0 : 255;
        return 10 * c;
    endfunction

    // Hand-derived results indexed by the bottom-right column c of the window
    function automatic int exp_of(input int kind, input int md, input int thr, input int c);
        if (kind == 1 && md == 0) return (c == 4 || c == 5) ? 255 : 0;
        if (kind == 2 && md == 3) return (thr <= 80) ? 255 : 0;
        return 0;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (frame_done === 1'b1) n_done++;
        if (done_pend != 0) check("frame_done", int'(frame_done), 1);
        else if (frame_done === 1'b1) check("spurious_frame_done", 1, 0);
        done_pend = 0;
        if (out_valid === 1'b1) begin
            n_out++;
            if (exp_q.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("pixel", int'(out_pixel), e.pix);
                check("latency", cyc, e.t + 3);
                check("out_sof", int'(out_sof), e.sof);
                check("out_eol", int'(out_eol), e.eol);
                done_pend = e.last;
            end
        end else if (out_pixel !== '0 || out_sof !== 1'b0 || out_eol !== 1'b0) begin
            idle_bad++;
        end
    end

    task automatic send(input int kind, input int nbeats, input bit with_sof,
                        input bit expect_on, input int maxgap, input int md, input int thr);
        mode   = 2'(md);
        thresh = 12'(thr);
        for (int i = 0; i < nbeats; i++) begin
            int   r, c, g;
            exp_t e;
            r = (i / W) % H;
            c = i % W;
            in_valid = 1'b1;
            in_sof   = with_sof && (i == 0);
            in_pixel = 8'(pix_of(kind, c));
            @(posedge clk);
            #1;
            if (expect_on && r >= 2 && c >= 2) begin
                e.pix  = exp_of(kind, md, thr, c);
                e.sof  = (r == 2 && c == 2) ? 1 : 0;
                e.eol  = (c == W - 1) ? 1 : 0;
                e.last = (r == H - 1 && c == W - 1) ? 1 : 0;
                e.t    = cyc;
                exp_q.push_back(e);
            end
            in_valid = 1'b0;
            in_sof   = 1'b0;
            g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            repeat (g) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic drain(input string tag, input int base_out, input int want_out,
                         input int base_done, input int want_done);
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        check({tag, "_leftover"}, exp_q.size(), 0);
        check({tag, "_n_out"}, n_out - base_out, want_out);
        check({tag, "_n_done"}, n_done - base_done, want_done);
        exp_q.delete();
    endtask

    initial begin
        int bo, bd;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_pixel", int'(out_pixel), 0);
        check("rst_frame_done", int'(frame_done), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        bo = n_out; bd = n_done;
        send(0, W * H, 1'b1, 1'b1, 0, 2, 0);
        drain("const_m2", bo, 24, bd, 1);

        bo = n_out; bd = n_done;
        send(1, W * H, 1'b1, 1'b1, 0, 0, 0);
        drain("step_m0", bo, 24, bd, 1);

        bo = n_out; bd = n_done;
        send(1, W * H, 1'b1, 1'b1, 0, 1, 0);
        drain("step_m1", bo, 24, bd, 1);

        bo = n_out; bd = n_done;
        send(2, W * H, 1'b1, 1'b1, 0, 3, 80);
        drain("ramp_t80", bo, 24, bd, 1);

        bo = n_out; bd = n_done;
        send(2, W * H, 1'b1, 1'b1, 0, 3, 81);
        drain("ramp_t81", bo, 24, bd, 1);

        bo = n_out; bd = n_done;
        send(2, W * H, 1'b1, 1'b1, 5, 3, 80);
        drain("ramp_gaps", bo, 24, bd, 1);

        // Reset after 20 beats, then unsynchronised beats, then a clean frame
        bo = n_out; bd = n_done;
        send(0, 20, 1'b1, 1'b0, 0, 2, 0);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_out_pixel", int'(out_pixel), 0);
        check("midrst_out_eol", int'(out_eol), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        send(0, 10, 1'b0, 1'b0, 0, 2, 0);
        send(1, W * H, 1'b1, 1'b1, 0, 0, 0);
        drain("midrst", bo, 24, bd, 1);

        // Resync at beat 30: 10 outputs from the partial frame, then 24 clean ones
        bo = n_out; bd = n_done;
        send(0, 30, 1'b1, 1'b1, 0, 2, 0);
        send(2, W * H, 1'b1, 1'b1, 0, 3, 80);
        drain("resync", bo, 34, bd, 1);

        check("idle_outputs_zero", idle_bad, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
